// File: rtl/fp_round_pipe_if.sv
// rtl/fp_round_pipe_if.sv - handshake bundle for the FP significand rounder
interface fp_round_pipe_if #(
  parameter int PROD_W = 48,
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [PROD_W-1:0] in_prod;
  logic [1:0]        in_rmode;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MANT_W-1:0] out_mant;
  logic              out_inexact;
  logic              out_ovf;

  modport master (
    output in_valid, in_sign, in_exp, in_prod, in_rmode, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_inexact, out_ovf
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_prod, in_rmode, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_inexact, out_ovf
  );
endinterface

// File: rtl/fp_round_pipe.sv
// rtl/fp_round_pipe.sv - 2-stage valid/ready rounder for the FP multiplier datapath
module fp_round_pipe #(
  parameter int PROD_W = 48,
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
) (
  input logic           clk,
  input logic           rst,
  fp_round_pipe_if.slave bus
);
  localparam int GI = PROD_W - 2 - MANT_W;

  logic [MANT_W-1:0] m;
  logic              g, r, s, special, inc, inexact;
  logic              unused_hidden;

  assign m             = bus.in_prod[PROD_W-2 -: MANT_W];
  assign g             = bus.in_prod[GI];
  assign r             = bus.in_prod[GI-1];
  assign unused_hidden = bus.in_prod[PROD_W-1];
  assign special       = &bus.in_exp;

  generate
    if (GI >= 2) begin : g_sticky
      assign s = |bus.in_prod[GI-2:0];
    end else begin : g_no_sticky
      assign s = 1'b0;
    end
  endgenerate

  assign inexact = (g | r | s) & ~special;

  always_comb begin
    inc = 1'b0;
    case (bus.in_rmode)
      2'd0:    inc = g & (r | s | m[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = (g | r | s) & ~bus.in_sign;
      default: inc = (g | r | s) & bus.in_sign;
    endcase
    if (special) inc = 1'b0;
  end

  logic              s1_v, s1_sign, s1_inc, s1_inexact, s1_special;
  logic [EXP_W-1:0]  s1_exp;
  logic [MANT_W-1:0] s1_m;

  logic              s2_v, s2_sign, s2_inexact, s2_ovf;
  logic [EXP_W-1:0]  s2_exp;
  logic [MANT_W-1:0] s2_mant;

  logic s2_adv, s1_adv;
  assign s2_adv       = ~s2_v | bus.out_ready;
  assign s1_adv       = ~s1_v | s2_adv;
  assign bus.in_ready = ~rst & s1_adv;

  logic [MANT_W:0]   sum;
  logic [EXP_W-1:0]  exp_p1;
  logic              carry;
  assign sum    = {1'b0, s1_m} + {{MANT_W{1'b0}}, s1_inc};
  assign exp_p1 = s1_exp + {{(EXP_W-1){1'b0}}, 1'b1};
  assign carry  = sum[MANT_W] & ~s1_special;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v       <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_m       <= '0;
      s1_inc     <= 1'b0;
      s1_inexact <= 1'b0;
      s1_special <= 1'b0;
      s2_v       <= 1'b0;
      s2_sign    <= 1'b0;
      s2_exp     <= '0;
      s2_mant    <= '0;
      s2_inexact <= 1'b0;
      s2_ovf     <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_sign    <= s1_sign;
          s2_inexact <= s1_inexact;
          // Mantissa wrap on carry renormalises to 1.0; all-ones exponent means infinity.
          s2_mant    <= carry ? '0 : sum[MANT_W-1:0];
          s2_exp     <= carry ? exp_p1 : s1_exp;
          s2_ovf     <= carry & (&exp_p1);
        end
      end
      if (s1_adv) begin
        s1_v <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sign    <= bus.in_sign;
          s1_exp     <= bus.in_exp;
          s1_m       <= m;
          s1_inc     <= inc;
          s1_inexact <= inexact;
          s1_special <= special;
        end
      end
    end
  end

  assign bus.out_valid   = s2_v;
  assign bus.out_sign    = s2_sign;
  assign bus.out_exp     = s2_exp;
  assign bus.out_mant    = s2_mant;
  assign bus.out_inexact = s2_inexact;
  assign bus.out_ovf     = s2_ovf;
endmodule

// File: tb/tb_fp_round_pipe.sv
// tb/tb_fp_round_pipe.sv - directed self-checking bench for fp_round_pipe
module tb_fp_round_pipe;
  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  fp_round_pipe_if #(.PROD_W(48), .MANT_W(23), .EXP_W(8)) bus ();

  fp_round_pipe #(.PROD_W(48), .MANT_W(23), .EXP_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic        x;
    logic        o;
  } res_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_dir(input string tag, input logic sg, input logic [7:0] e, input logic [47:0] p,
                         input logic [1:0] rm, input logic [22:0] em, input logic [7:0] ee,
                         input logic einx, input logic eovf);
    int n;
    bus.in_valid = 1'b1;
    bus.in_sign  = sg;
    bus.in_exp   = e;
    bus.in_prod  = p;
    bus.in_rmode = rm;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_sign"}, 64'(bus.out_sign), 64'(sg));
    check({tag, "_mant"}, 64'(bus.out_mant), 64'(em));
    check({tag, "_exp"}, 64'(bus.out_exp), 64'(ee));
    check({tag, "_inexact"}, 64'(bus.out_inexact), 64'(einx));
    check({tag, "_ovf"}, 64'(bus.out_ovf), 64'(eovf));
    @(posedge clk); #1;
  endtask

  initial begin
    res_t        q[$];
    res_t        snap, got, want;
    logic        stalled, acc, inc;
    logic [22:0] sm;
    logic [1:0]  srm;
    logic        ssg;
    int          sent, rcvd, occ, cyc;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_prod   = '0;
    bus.in_rmode  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_fields", 64'({bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inexact, bus.out_ovf}), 64'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    run_dir("rne_even", 1'b0, 8'h10, 48'h8000_0080_0000, 2'd0, 23'h0, 8'h10, 1'b1, 1'b0);
    run_dir("rne_odd",  1'b0, 8'h10, 48'h8000_0180_0000, 2'd0, 23'h2, 8'h10, 1'b1, 1'b0);
    run_dir("rtz_odd",  1'b0, 8'h10, 48'h8000_0180_0000, 2'd1, 23'h1, 8'h10, 1'b1, 1'b0);
    run_dir("carry",    1'b0, 8'h10, 48'hFFFF_FF80_0000, 2'd0, 23'h0, 8'h11, 1'b1, 1'b0);
    run_dir("carry_ovf",1'b0, 8'hFE, 48'hFFFF_FF80_0000, 2'd0, 23'h0, 8'hFF, 1'b1, 1'b1);
    run_dir("rdn_neg",  1'b1, 8'h10, 48'h8000_0000_0001, 2'd3, 23'h1, 8'h10, 1'b1, 1'b0);
    run_dir("rup_neg",  1'b1, 8'h10, 48'h8000_0000_0001, 2'd2, 23'h0, 8'h10, 1'b1, 1'b0);
    run_dir("exact_m0", 1'b1, 8'h42, 48'h8ABC_DE00_0000, 2'd0, 23'h0ABCDE, 8'h42, 1'b0, 1'b0);
    run_dir("exact_m1", 1'b1, 8'h42, 48'h8ABC_DE00_0000, 2'd1, 23'h0ABCDE, 8'h42, 1'b0, 1'b0);
    run_dir("exact_m2", 1'b1, 8'h42, 48'h8ABC_DE00_0000, 2'd2, 23'h0ABCDE, 8'h42, 1'b0, 1'b0);
    run_dir("exact_m3", 1'b1, 8'h42, 48'h8ABC_DE00_0000, 2'd3, 23'h0ABCDE, 8'h42, 1'b0, 1'b0);
    run_dir("special",  1'b0, 8'hFF, 48'hFFFF_FFFF_FFFF, 2'd2, 23'h7FFFFF, 8'hFF, 1'b0, 1'b0);
    run_dir("special_n",1'b1, 8'hFF, 48'h8000_01FF_FFFF, 2'd3, 23'h000001, 8'hFF, 1'b0, 1'b0);

    // Stream with alternating out_ready and random input gaps against an occupancy model.
    sent    = 0;
    rcvd    = 0;
    occ     = 0;
    cyc     = 0;
    stalled = 1'b0;
    snap    = '0;
    while (rcvd < 8 && cyc < 300) begin
      bus.out_ready = (cyc % 2 == 0);
      sm  = 23'(sent * 5 + 2);
      ssg = sent[0];
      srm = 2'(sent % 4);
      if (sent < 8 && $urandom_range(0, 3) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_sign  = ssg;
        bus.in_exp   = 8'(8'h20 + sent);
        bus.in_prod  = {1'b1, sm, 1'b1, 23'h0};
        bus.in_rmode = srm;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      got = '{s: bus.out_sign, e: bus.out_exp, m: bus.out_mant, x: bus.out_inexact, o: bus.out_ovf};
      if (stalled) check("stall_hold", 64'({bus.out_valid, got}), 64'({1'b1, snap}));
      check("stream_in_ready", 64'(bus.in_ready), 64'(!(occ == 2 && !bus.out_ready)));
      acc = bus.in_valid & bus.in_ready;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (q.size() == 0) begin
            check("stream_extra_out", 64'd1, 64'd0);
          end else begin
            want = q.pop_front();
            check("stream_result", 64'(got), 64'(want));
          end
          rcvd++;
          occ--;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          snap    = got;
        end
      end else begin
        stalled = 1'b0;
      end
      if (acc) begin
        case (srm)
          2'd0:    inc = sm[0];
          2'd1:    inc = 1'b0;
          2'd2:    inc = ~ssg;
          default: inc = ssg;
        endcase
        want = '{s: ssg, e: 8'(8'h20 + sent), m: sm + 23'(inc), x: 1'b1, o: 1'b0};
        q.push_back(want);
        sent++;
        occ++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("stream_count", 64'(rcvd), 64'd8);
    check("stream_queue_empty", 64'(q.size()), 64'd0);

    // Reset with two transactions in flight.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 8'h30;
    bus.in_prod   = 48'h8000_0180_0000;
    bus.in_rmode  = 2'd0;
    @(posedge clk); #1;
    bus.in_exp    = 8'h31;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("flight_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("flight_rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("flight_rel_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    check("flight_no_spurious", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("flight_no_spurious2", 64'(bus.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
